// File: rtl/wishbone_timer.sv
// wishbone_timer
//   Machine-timer style 64-bit counter on a Wishbone slave port, with a
//   prescaler and a level interrupt when mtime >= mtimecmp.
//
//   Registers (word index i_ADDR[4:2]):
//     0 MTIME_LO    1 MTIME_HI (returns shadow captured by the last LO read)
//     2 MTIMECMP_LO 3 MTIMECMP_HI
//     4 CTRL (bit0 EN, bit1 IRQ_EN)   5 PRESCALE   6,7 unmapped (read 0)
//
//   Ports:
//     i_CLK, i_RSTN        clock, asynchronous active-low reset
//     i_ADDR, i_DATA       byte address, write data
//     i_WE, i_SEL          write enable, byte-lane enables
//     i_STB, i_CYC         Wishbone strobe / cycle
//     o_DATA, o_ACK        read data (zero unless acking a read), ack pulse
//     o_IRQ                registered timer interrupt level
module wishbone_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTN,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    output logic                  o_IRQ
);

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtimecmp_reg;
    logic [1:0]  ctrl_reg;
    logic [31:0] prescale_reg;
    logic [31:0] pre_cnt_reg, pre_cnt_next;
    logic [31:0] hi_shadow_reg;
    logic [31:0] data_reg;
    logic        ack_reg;
    logic        irq_reg;

    logic [2:0]  reg_sel;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic [31:0] byte_mask;
    logic [31:0] reg_cur;
    logic [31:0] wdata_merged;
    logic [31:0] read_value;

    // Only address bits [4:2] are decoded; the rest are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0]};

    assign reg_sel = i_ADDR[4:2];
    // ack_reg gates acceptance so a held strobe is acked every other cycle.
    assign accept  = i_CYC & i_STB & ~ack_reg;
    assign wr_en   = accept & i_WE;
    assign rd_en   = accept & ~i_WE;
    assign tick    = ctrl_reg[0] && (pre_cnt_reg == prescale_reg);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_mask[8*gi +: 8] = {8{i_SEL[gi]}};
    end

    // Live value of the addressed register, used as the base of a partial write.
    always_comb begin
        reg_cur = 32'd0;
        case (reg_sel)
            REG_MTIME_LO:    reg_cur = mtime_reg[31:0];
            REG_MTIME_HI:    reg_cur = mtime_reg[63:32];
            REG_MTIMECMP_LO: reg_cur = mtimecmp_reg[31:0];
            REG_MTIMECMP_HI: reg_cur = mtimecmp_reg[63:32];
            REG_CTRL:        reg_cur = {30'd0, ctrl_reg};
            REG_PRESCALE:    reg_cur = prescale_reg;
            default:         reg_cur = 32'd0;
        endcase
    end

    assign wdata_merged = (reg_cur & ~byte_mask) | (i_DATA & byte_mask);

    // MTIME_HI reads come from the shadow so a LO/HI pair is tear-free.
    assign read_value = (reg_sel == REG_MTIME_HI) ? hi_shadow_reg : reg_cur;

    // A bus write to either half replaces this edge's increment entirely.
    always_comb begin
        mtime_next = tick ? mtime_reg + 64'd1 : mtime_reg;
        if (wr_en && reg_sel == REG_MTIME_LO)
            mtime_next = {mtime_reg[63:32], wdata_merged};
        else if (wr_en && reg_sel == REG_MTIME_HI)
            mtime_next = {wdata_merged, mtime_reg[31:0]};
    end

    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        if (wr_en && reg_sel == REG_PRESCALE)
            pre_cnt_next = 32'd0;
        else if (ctrl_reg[0])
            pre_cnt_next = tick ? 32'd0 : pre_cnt_reg + 32'd1;
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            mtime_reg     <= 64'd0;
            mtimecmp_reg  <= {64{1'b1}};
            ctrl_reg      <= 2'd0;
            prescale_reg  <= 32'd0;
            pre_cnt_reg   <= 32'd0;
            hi_shadow_reg <= 32'd0;
            data_reg      <= 32'd0;
            ack_reg       <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            mtime_reg   <= mtime_next;
            pre_cnt_reg <= pre_cnt_next;
            ack_reg     <= accept;
            data_reg    <= rd_en ? read_value : 32'd0;
            irq_reg     <= ctrl_reg[1] && (mtime_reg >= mtimecmp_reg);

            if (rd_en && reg_sel == REG_MTIME_LO)
                hi_shadow_reg <= mtime_reg[63:32];

            if (wr_en) begin
                case (reg_sel)
                    REG_MTIMECMP_LO: mtimecmp_reg[31:0]  <= wdata_merged;
                    REG_MTIMECMP_HI: mtimecmp_reg[63:32] <= wdata_merged;
                    REG_CTRL:        ctrl_reg            <= wdata_merged[1:0];
                    REG_PRESCALE:    prescale_reg        <= wdata_merged;
                    default:         ;
                endcase
            end
        end
    end

    assign o_DATA = data_reg;
    assign o_ACK  = ack_reg;
    assign o_IRQ  = irq_reg;

endmodule

// File: tb/tb_wishbone_timer.sv
// Testbench for wishbone_timer: directed scenarios plus randomized bus
// traffic, compared against a register-level reference model.
module tb_wishbone_timer;

    logic        i_CLK = 1'b0;
    logic        i_RSTN = 1'b0;
    logic [31:0] i_ADDR = '0;
    logic [31:0] i_DATA = '0;
    logic [31:0] o_DATA;
    logic        i_WE = 1'b0;
    logic [3:0]  i_SEL = '0;
    logic        i_STB = 1'b0;
    logic        i_CYC = 1'b0;
    logic        o_ACK;
    logic        o_IRQ;

    always #5 i_CLK = ~i_CLK;

    wishbone_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN), .i_ADDR(i_ADDR), .i_DATA(i_DATA),
        .o_DATA(o_DATA), .i_WE(i_WE), .i_SEL(i_SEL), .i_STB(i_STB),
        .i_CYC(i_CYC), .o_ACK(o_ACK), .o_IRQ(o_IRQ)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: the architectural registers as plain numbers.
    logic [63:0] m_mtime, m_cmp;
    logic [1:0]  m_ctrl;
    logic [31:0] m_pre, m_pcnt, m_shadow;
    logic        m_ack;
    logic        exp_ack, exp_irq;
    logic [31:0] exp_data;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0] sel);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ctrl};
            3'd5: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_ctrl = 2'd0;
        m_pre = 32'd0; m_pcnt = 32'd0; m_shadow = 32'd0; m_ack = 1'b0;
        exp_ack = 1'b0; exp_data = 32'd0; exp_irq = 1'b0;
    endtask

    // Drive one cycle of bus inputs, advance the model by one edge, and
    // leave time 1 unit after the edge.
    task automatic step(input bit cyc, input bit stb, input bit we,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
        logic        acc, irq_n, inc;
        logic [2:0]  a;
        logic [31:0] rv, pc_n, tmp;
        logic [63:0] mt_n;
        i_CYC = cyc; i_STB = stb; i_WE = we; i_ADDR = addr; i_DATA = data; i_SEL = sel;
        acc   = cyc && stb && !m_ack;
        a     = addr[4:2];
        rv    = model_read(a);
        irq_n = m_ctrl[1] && (m_mtime >= m_cmp);
        inc   = m_ctrl[0] && (m_pcnt == m_pre);
        mt_n  = inc ? m_mtime + 64'd1 : m_mtime;
        pc_n  = !m_ctrl[0] ? m_pcnt : (inc ? 32'd0 : m_pcnt + 32'd1);
        if (acc && we) begin
            case (a)
                3'd0: mt_n = {m_mtime[63:32], lane_merge(m_mtime[31:0], data, sel)};
                3'd1: mt_n = {lane_merge(m_mtime[63:32], data, sel), m_mtime[31:0]};
                3'd2: m_cmp[31:0]  = lane_merge(m_cmp[31:0], data, sel);
                3'd3: m_cmp[63:32] = lane_merge(m_cmp[63:32], data, sel);
                3'd4: begin tmp = lane_merge({30'd0, m_ctrl}, data, sel); m_ctrl = tmp[1:0]; end
                3'd5: begin m_pre = lane_merge(m_pre, data, sel); pc_n = 32'd0; end
                default: ;
            endcase
        end
        if (acc && !we && a == 3'd0) m_shadow = m_mtime[63:32];
        m_mtime  = mt_n;
        m_pcnt   = pc_n;
        m_ack    = acc;
        exp_ack  = acc;
        exp_data = (acc && !we) ? rv : 32'd0;
        exp_irq  = irq_n;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] sel);
        step(1, 1, 1, addr, data, sel);
        idle(1);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic got_ack,
                            output logic [31:0] got_data, output logic [31:0] want_data);
        step(1, 1, 0, addr, $urandom, 4'($urandom));
        got_ack = o_ACK; got_data = o_DATA; want_data = exp_data;
        idle(1);
    endtask

    // Assert reset away from the clock edge, sample outputs 1 time unit later.
    task automatic pulse_reset(output logic a, output logic [31:0] d, output logic q);
        i_CYC = 0; i_STB = 0; i_WE = 0;
        i_RSTN = 1'b0;
        model_reset();
        #1;
        a = o_ACK; d = o_DATA; q = o_IRQ;
        @(posedge i_CLK);
        #2;
        i_RSTN = 1'b1;
        idle(1);
    endtask

    task automatic read_all_reset_values(input string tag);
        logic        ga;
        logic [31:0] gd, wd;
        logic [31:0] rst_val [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        for (int r = 0; r < 6; r++) begin
            bus_read(32'(r * 4), ga, gd, wd);
            checks++;
            if (ga !== 1'b1 || gd !== rst_val[r] || gd !== wd) begin
                failures++;
                $display("FAIL %s reg%0d ack=%b got=%h want=%h", tag, r, ga, gd, rst_val[r]);
            end
        end
    endtask

    task automatic test_reset();
        logic a, q;
        logic [31:0] d;
        pulse_reset(a, d, q);
        checks++;
        if ({a, d, q} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b data=%h irq=%b want all 0", a, d, q);
        end
        read_all_reset_values("reset_regs");
    endtask

    task automatic test_prescale0();
        logic        ga;
        logic [31:0] gd, wd;
        bus_write(32'h14, 32'd0, 4'hF);
        bus_write(32'h10, 32'd3, 4'hF);
        idle(9);
        bus_read(32'h00, ga, gd, wd);
        checks++;
        if (ga !== 1'b1 || gd !== wd || gd < 32'd9 || gd > 32'd11) begin
            failures++;
            $display("FAIL count_p0 ack=%b got=%0d want=%0d (10+-1)", ga, gd, wd);
        end
    endtask

    task automatic test_wrap();
        logic        ga;
        logic [31:0] gd, wd;
        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h00, 32'hFFFF_FFFE, 4'hF);
        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h14, 32'd0, 4'hF);
        bus_write(32'h10, 32'd1, 4'hF);
        idle(3);
        bus_read(32'h00, ga, gd, wd);
        checks++;
        if (gd !== wd) begin failures++; $display("FAIL carry_lo got=%h want=%h", gd, wd); end
        bus_read(32'h04, ga, gd, wd);
        checks++;
        if (gd !== wd || gd !== 32'd1) begin failures++; $display("FAIL carry_hi got=%h want=%h", gd, 32'd1); end
        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h04, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h10, 32'd1, 4'hF);
        bus_read(32'h00, ga, gd, wd);
        checks++;
        if (gd !== wd || gd !== 32'd0) begin failures++; $display("FAIL wrap_lo got=%h want=%h", gd, 32'd0); end
        bus_read(32'h04, ga, gd, wd);
        checks++;
        if (gd !== wd || gd !== 32'd0) begin failures++; $display("FAIL wrap_hi got=%h want=%h", gd, 32'd0); end
    endtask

    task automatic test_prescale3();
        logic        ga;
        logic [31:0] gd, wd, first;
        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h00, 32'd0, 4'hF);
        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h14, 32'd3, 4'hF);
        bus_write(32'h10, 32'd1, 4'hF);
        for (int k = 0; k < 6; k++) begin
            idle(k % 3);
            bus_read(32'h00, ga, gd, wd);
            checks++;
            if (gd !== wd) begin failures++; $display("FAIL pre3_read%0d got=%0d want=%0d", k, gd, wd); end
            if (k == 3) bus_write(32'h14, 32'd3, 4'hF);
        end
        // Eight edges with PRESCALE=3 contain exactly two increments.
        step(1, 1, 0, 32'h00, 32'd0, 4'hF);
        first = o_DATA;
        idle(7);
        step(1, 1, 0, 32'h00, 32'd0, 4'hF);
        checks++;
        if (o_DATA - first !== 32'd2 || o_DATA !== exp_data) begin
            failures++;
            $display("FAIL pre3_rate got=%0d want=%0d", o_DATA - first, 32'd2);
        end
        idle(1);
    endtask

    task automatic test_irq();
        int bad = 0;
        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h00, 32'd0, 4'hF);
        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h14, 32'd0, 4'hF);
        bus_write(32'h08, 32'd20, 4'hF);
        bus_write(32'h0C, 32'd0, 4'hF);
        bus_write(32'h10, 32'd3, 4'hF);
        for (int i = 0; i < 30; i++) begin
            idle(1);
            checks++;
            if (o_IRQ !== exp_irq) begin
                failures++; bad++;
                $display("FAIL irq_rise cyc%0d got=%b want=%b", i, o_IRQ, exp_irq);
            end
        end
        checks++;
        if (o_IRQ !== 1'b1) begin failures++; $display("FAIL irq_high got=%b want=1", o_IRQ); end
        step(1, 1, 1, 32'h0C, 32'd1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_IRQ !== exp_irq) begin
                failures++;
                $display("FAIL irq_fall cyc%0d got=%b want=%b", i, o_IRQ, exp_irq);
            end
            idle(1);
        end
        checks++;
        if (o_IRQ !== 1'b0) begin failures++; $display("FAIL irq_low got=%b want=0", o_IRQ); end
    endtask

    task automatic test_byte_sel();
        logic        a, q, ga;
        logic [31:0] d, gd, wd;
        pulse_reset(a, d, q);
        bus_write(32'h08, 32'hAABB_CCDD, 4'b0100);
        bus_read(32'h08, ga, gd, wd);
        checks++;
        if (gd !== wd || gd !== 32'hFFBB_FFFF) begin
            failures++; $display("FAIL byte_sel got=%h want=%h", gd, 32'hFFBB_FFFF);
        end
        bus_write(32'h18, 32'h1234_5678, 4'hF);
        bus_read(32'h18, ga, gd, wd);
        checks++;
        if (ga !== 1'b1 || gd !== 32'd0) begin
            failures++; $display("FAIL unmapped ack=%b got=%h want=0", ga, gd);
        end
    endtask

    task automatic test_random();
        bit          cyc, stb, we;
        logic [31:0] addr;
        for (int t = 0; t < 400; t++) begin
            cyc  = ($urandom_range(0, 7) != 0);
            stb  = ($urandom_range(0, 5) != 0);
            we   = $urandom_range(0, 1) == 1;
            addr = {$urandom} & 32'hFFFF_FFFC;
            // Keep writes mostly away from mtime so the counter runs.
            if (we && addr[4:3] == 2'b00 && $urandom_range(0, 3) != 0) addr[4:2] = 3'd5;
            step(cyc, stb, we, addr, $urandom, 4'($urandom));
            checks++;
            if (o_ACK !== exp_ack || o_DATA !== exp_data || o_IRQ !== exp_irq) begin
                failures++;
                $display("FAIL random t%0d a=%0d we=%b got ack=%b d=%h irq=%b want ack=%b d=%h irq=%b",
                         t, addr[4:2], we, o_ACK, o_DATA, o_IRQ, exp_ack, exp_data, exp_irq);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic ga;
        logic [31:0] gd, wd;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (o_ACK !== 1'(k % 2) || o_ACK !== m_ack) begin
                failures++; $display("FAIL ack_pattern k%0d got=%b want=%b", k, o_ACK, 1'(k % 2));
            end
            step(1, 1, 0, 32'h14, 32'd0, 4'hF);
        end
        step(1, 1, 0, 32'h14, 32'd0, 4'hF);
        checks++;
        if (o_ACK !== 1'b1) begin failures++; $display("FAIL ack_before_rst got=%b want=1", o_ACK); end
        i_RSTN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_ACK !== 1'b0 || o_DATA !== 32'd0 || o_IRQ !== 1'b0) begin
            failures++; $display("FAIL rst_mid ack=%b data=%h irq=%b want 0", o_ACK, o_DATA, o_IRQ);
        end
        i_CYC = 0; i_STB = 0;
        @(posedge i_CLK);
        #2;
        i_RSTN = 1'b1;
        bus_read(32'h14, ga, gd, wd);
        checks++;
        if (ga !== 1'b1 || gd !== wd) begin
            failures++; $display("FAIL first_after_rst ack=%b got=%h want=%h", ga, gd, wd);
        end
        read_all_reset_values("rst_mid_regs");
    endtask

    initial begin
        model_reset();
        @(posedge i_CLK);
        #1;
        test_reset();
        test_prescale0();
        test_wrap();
        test_prescale3();
        test_irq();
        test_byte_sel();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
